pipeline_ex_stage5: RTL
=======================

// Module: pipeline_ex_stage5
// PURPOSE
//  Execute stage of the pipelined RV64 CPU; consumes the IDR-stage register outputs.
//  Computes the ALU/branch result and resolves jumps/branches (combinational redirect).
//  Runs the M-extension: 1-cycle multiply, iterative radix-2 divide/remainder.
//  Drives the EX/MEM pipeline register and a busy request to the hazard unit.
// PARAMETERS
//  XLEN      64  datapath width
//  DIV_ITERS 64  divide iterations, = XLEN
// PORTS
//  clk              in   1     clock
//  reset            in   1     asynchronous reset, active-low
//  stall            in   1     downstream stall: hold EX/MEM register
//  flush            in   1     squash: EX/MEM gets a bubble, divider aborts
//  pc_IDR           in   64    instruction PC
//  reg_data1_IDR    in   64    rs1 value (already forwarded)
//  reg_data2_IDR    in   64    rs2 value (already forwarded)
//  imm_IDR          in   64    immediate
//  rd_IDR           in   5     destination register
//  rf_wr_en_IDR     in   1     regfile write enable (0 = bubble)
//  rf_wr_sel_IDR    in   2     writeback source select, passed through
//  do_jump_IDR      in   1     JAL/JALR
//  is_branch_IDR    in   1     conditional branch
//  alu_a_sel_IDR    in   1     ALU A: 0 = rs1, 1 = pc
//  alu_b_sel_IDR    in   1     ALU B: 0 = rs2, 1 = imm
//  alu_ctrl_IDR     in   4     ALU op, or M-op when m_sel_IDR = 1
//  BrType_IDR       in   3     branch funct3
//  m_sel_IDR        in   1     M-extension op
//  dm_rd_ctrl_IDR   in   3     load control, passed through
//  dm_wr_ctrl_IDR   in   3     store control, passed through
//  redirect_EX      out  1     taken jump/branch (combinational)
//  redirect_pc_EX   out  64    redirect target (combinational)
//  md_busy_EX       out  1     divider busy: stall upstream stages (combinational)
//  pc_EX, alu_result_EX, store_data_EX  out  64   EX/MEM register
//  rd_EX 5 / rf_wr_en_EX 1 / rf_wr_sel_EX 2 / dm_rd_ctrl_EX 3 / dm_wr_ctrl_EX 3
//                   out        EX/MEM register, passed through
// BEHAVIOUR
//  Reset
//   - All registered outputs reset to 0.
//   - Divider state = IDLE; counter and working registers cleared.
//  Operands
//   - A = alu_a_sel ? pc : rs1.
//   - B = alu_b_sel ? imm : rs2.
//  ALU ops (alu_ctrl)
//   - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
//   - 11-15 give result 0.
//   - Shift amount = B[5:0].
//  M ops (m_sel = 1)
//   - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU; 8-15 give 0.
//   - MUL* are combinational; their result is latched in the same cycle.
//  Branches (BrType)
//   - 0 EQ, 1 NE, 4 LT, 5 GE, 6 LTU, 7 GEU; other encodings are not taken.
//  Redirect
//   - redirect_EX = ~flush & ~md_busy_EX & (do_jump | (is_branch & cond)).
//   - Target for a jump = {result[63:1], 1'b0}.
//   - Target for a branch = pc + imm.
//  EX/MEM register, priority per clock
//   - stall: hold.
//   - else flush: all fields 0.
//   - else md_busy_EX: all fields 0 (bubble).
//   - else: load stage outputs; store_data = rs2.
//  Divider FSM: IDLE -> RUN -> DONE -> IDLE
//   - IDLE: a div/rem op is present and flush = 0 -> latch |dividend|, |divisor| and
//     sign flags, counter = 0, go to RUN.
//   - Special cases go straight to DONE with the result fixed:
//     - divisor == 0: quotient = all-ones, remainder = dividend.
//     - signed MIN / -1: quotient = MIN, remainder = 0.
//   - RUN: one restoring shift-subtract step per cycle, counter++.
//     Go to DONE after DIV_ITERS steps.
//   - DONE: apply sign correction (quotient sign = sA ^ sB, remainder sign = sA).
//     The result feeds the EX/MEM load; md_busy_EX = 0.
//     DONE -> IDLE only on a clock where stall = 0; otherwise stay in DONE.
//   - md_busy_EX = div/rem op present & state != DONE.
//   - Normal latency: busy from cycle N for DIV_ITERS + 1 cycles; EX/MEM loads at the
//     end of cycle N + DIV_ITERS + 1.
//   - flush in any state -> IDLE next edge; no result is written.
//   - stall during RUN: iteration continues.
//   - reset mid-divide: IDLE immediately (asynchronous).
// TESTING
//  - ADD: rs1 = 5, imm = -7, alu_b_sel = 1 -> alu_result_EX = 0xFFFF_FFFF_FFFF_FFFE
//    one clock later.
//  - BLT: rs1 = -1, rs2 = 0 -> redirect_EX = 1, redirect_pc_EX = pc + imm,
//    in the same cycle.
//  - DIV: 100 / -7 -> md_busy_EX high for 65 cycles, then alu_result_EX = -14;
//    REM of the same operands gives 2.
//  - Divide by zero: DIVU x / 0 -> all-ones. Signed MIN / -1 -> MIN.
//    Both with busy for 1 cycle only.
//  - flush at iteration 30 of a DIV -> next edge FSM = IDLE, EX/MEM is a bubble;
//    a following ADD executes normally.
//  - stall asserted for 3 cycles while in DONE -> result held; committed once on
//    release; FSM -> IDLE.

Source files
------------

// File: rtl/pipeline_ex_stage5.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ex_stage5
// Description : Execute stage of the pipelined RV64 CPU.
//               - ALU, branch compare and combinational jump/branch redirect
//               - M extension: single-cycle multiply, iterative radix-2
//                 restoring divide/remainder with busy request to hazard unit
//               - EX/MEM pipeline register (stall holds, flush/busy bubble)
// Ports       : clk, reset (async, active-low), stall, flush
//               *_IDR  : operands and control from the IDR stage register
//               redirect_EX / redirect_pc_EX : taken jump/branch and target
//               md_busy_EX : divider needs more cycles, stall upstream
//               *_EX   : EX/MEM register outputs
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ex_stage5 #(
    parameter int XLEN      = 64,
    parameter int DIV_ITERS = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_IDR,
    input  logic [XLEN-1:0] reg_data1_IDR,
    input  logic [XLEN-1:0] reg_data2_IDR,
    input  logic [XLEN-1:0] imm_IDR,
    input  logic [4:0]      rd_IDR,
    input  logic            rf_wr_en_IDR,
    input  logic [1:0]      rf_wr_sel_IDR,
    input  logic            do_jump_IDR,
    input  logic            is_branch_IDR,
    input  logic            alu_a_sel_IDR,
    input  logic            alu_b_sel_IDR,
    input  logic [3:0]      alu_ctrl_IDR,
    input  logic [2:0]      BrType_IDR,
    input  logic            m_sel_IDR,
    input  logic [2:0]      dm_rd_ctrl_IDR,
    input  logic [2:0]      dm_wr_ctrl_IDR,
    output logic            redirect_EX,
    output logic [XLEN-1:0] redirect_pc_EX,
    output logic            md_busy_EX,
    output logic [XLEN-1:0] pc_EX,
    output logic [XLEN-1:0] alu_result_EX,
    output logic [XLEN-1:0] store_data_EX,
    output logic [4:0]      rd_EX,
    output logic            rf_wr_en_EX,
    output logic [1:0]      rf_wr_sel_EX,
    output logic [2:0]      dm_rd_ctrl_EX,
    output logic [2:0]      dm_wr_ctrl_EX
);

    localparam int SHW  = $clog2(XLEN);
    localparam int CNTW = $clog2(DIV_ITERS + 1);
    localparam logic [CNTW-1:0] C_LAST = CNTW'(DIV_ITERS - 1);
    localparam logic [XLEN-1:0] C_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ---------------- operands ----------------
    logic [XLEN-1:0] w_op_a, w_op_b;
    logic [SHW-1:0]  w_shamt;
    assign w_op_a  = alu_a_sel_IDR ? pc_IDR  : reg_data1_IDR;
    assign w_op_b  = alu_b_sel_IDR ? imm_IDR : reg_data2_IDR;
    assign w_shamt = w_op_b[SHW-1:0];

    // ---------------- ALU ----------------
    logic [XLEN-1:0] w_alu;
    always_comb begin
        w_alu = '0;
        case (alu_ctrl_IDR)
            4'd0:    w_alu = w_op_a + w_op_b;
            4'd1:    w_alu = w_op_a - w_op_b;
            4'd2:    w_alu = w_op_a << w_shamt;
            4'd3:    w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            4'd4:    w_alu = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
            4'd5:    w_alu = w_op_a ^ w_op_b;
            4'd6:    w_alu = w_op_a >> w_shamt;
            4'd7:    w_alu = $signed(w_op_a) >>> w_shamt;
            4'd8:    w_alu = w_op_a | w_op_b;
            4'd9:    w_alu = w_op_a & w_op_b;
            4'd10:   w_alu = w_op_b;
            default: w_alu = '0;
        endcase
    end

    // ---------------- multiplier ----------------
    // Operands are extended to 2*XLEN according to signedness so that a single
    // unsigned multiplier yields the exact low 2*XLEN bits for every MUL variant.
    logic            w_mul_sa, w_mul_sb;
    logic [2*XLEN-1:0] w_mul_a, w_mul_b, w_prod;
    assign w_mul_sa = (alu_ctrl_IDR == 4'd1) || (alu_ctrl_IDR == 4'd2);
    assign w_mul_sb = (alu_ctrl_IDR == 4'd1);
    assign w_mul_a  = {{XLEN{w_mul_sa & w_op_a[XLEN-1]}}, w_op_a};
    assign w_mul_b  = {{XLEN{w_mul_sb & w_op_b[XLEN-1]}}, w_op_b};
    assign w_prod   = w_mul_a * w_mul_b;

    // ---------------- divider datapath ----------------
    logic            w_div_op, w_div_signed, w_sa, w_sb, w_div_zero, w_div_ovf;
    logic [XLEN-1:0] w_abs_a, w_abs_b;
    assign w_div_op     = m_sel_IDR & (alu_ctrl_IDR[3:2] == 2'b01);
    assign w_div_signed = ~alu_ctrl_IDR[0];
    assign w_sa         = w_div_signed & w_op_a[XLEN-1];
    assign w_sb         = w_div_signed & w_op_b[XLEN-1];
    assign w_abs_a      = w_sa ? -w_op_a : w_op_a;
    assign w_abs_b      = w_sb ? -w_op_b : w_op_b;
    assign w_div_zero   = (w_op_b == '0);
    assign w_div_ovf    = w_div_signed & (w_op_a == C_MIN) & (w_op_b == '1);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            negq_q, negq_d, negr_q, negr_d;

    // quo_q holds the dividend bits still to be shifted in and the quotient
    // bits produced so far; rem_q is the partial remainder.
    logic [XLEN:0]   w_rem_shift, w_diff;
    assign w_rem_shift = {rem_q, quo_q[XLEN-1]};
    assign w_diff      = w_rem_shift - {1'b0, dvsr_q};

    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvsr_d = dvsr_q;
        cnt_d  = cnt_q;
        negq_d = negq_q;
        negr_d = negr_q;
        if ((state_q == S_IDLE) && w_div_op && !flush) begin
            cnt_d  = '0;
            dvsr_d = w_abs_b;
            if (w_div_zero) begin
                // Final values stored directly; sign correction disabled.
                quo_d  = '1;
                rem_d  = w_op_a;
                negq_d = 1'b0;
                negr_d = 1'b0;
            end else if (w_div_ovf) begin
                quo_d  = C_MIN;
                rem_d  = '0;
                negq_d = 1'b0;
                negr_d = 1'b0;
            end else begin
                quo_d  = w_abs_a;
                rem_d  = '0;
                negq_d = w_sa ^ w_sb;
                negr_d = w_sa;
            end
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q + CNTW'(1);
            if (!w_diff[XLEN]) begin
                rem_d = w_diff[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = w_rem_shift[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
        end
    end

    // ---------------- divider FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (w_div_op) state_d = (w_div_zero || w_div_ovf) ? S_DONE : S_RUN;
                S_RUN:   if (cnt_q == C_LAST) state_d = S_DONE;
                S_DONE:  if (!stall) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    logic [XLEN-1:0] w_div_res;
    always_comb begin
        md_busy_EX = w_div_op & (state_q != S_DONE);
        w_div_res  = alu_ctrl_IDR[1] ? (negr_q ? -rem_q : rem_q)
                                     : (negq_q ? -quo_q : quo_q);
    end

    // ---------------- result select ----------------
    logic [XLEN-1:0] w_result;
    always_comb begin
        w_result = w_alu;
        if (m_sel_IDR) begin
            case (alu_ctrl_IDR)
                4'd0:                w_result = w_prod[XLEN-1:0];
                4'd1, 4'd2, 4'd3:    w_result = w_prod[2*XLEN-1:XLEN];
                4'd4, 4'd5, 4'd6, 4'd7: w_result = w_div_res;
                default:             w_result = '0;
            endcase
        end
    end

    // ---------------- branch / redirect ----------------
    logic w_cond;
    always_comb begin
        case (BrType_IDR)
            3'd0:    w_cond = (reg_data1_IDR == reg_data2_IDR);
            3'd1:    w_cond = (reg_data1_IDR != reg_data2_IDR);
            3'd4:    w_cond = ($signed(reg_data1_IDR) <  $signed(reg_data2_IDR));
            3'd5:    w_cond = ($signed(reg_data1_IDR) >= $signed(reg_data2_IDR));
            3'd6:    w_cond = (reg_data1_IDR <  reg_data2_IDR);
            3'd7:    w_cond = (reg_data1_IDR >= reg_data2_IDR);
            default: w_cond = 1'b0;
        endcase
    end

    assign redirect_EX    = ~flush & ~md_busy_EX & (do_jump_IDR | (is_branch_IDR & w_cond));
    assign redirect_pc_EX = do_jump_IDR ? {w_result[XLEN-1:1], 1'b0} : (pc_IDR + imm_IDR);

    // ---------------- EX/MEM register ----------------
    logic w_kill;
    assign w_kill = flush | md_busy_EX;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_EX         <= '0;
            alu_result_EX <= '0;
            store_data_EX <= '0;
            rd_EX         <= '0;
            rf_wr_en_EX   <= 1'b0;
            rf_wr_sel_EX  <= '0;
            dm_rd_ctrl_EX <= '0;
            dm_wr_ctrl_EX <= '0;
        end else if (!stall) begin
            pc_EX         <= w_kill ? '0 : pc_IDR;
            alu_result_EX <= w_kill ? '0 : w_result;
            store_data_EX <= w_kill ? '0 : reg_data2_IDR;
            rd_EX         <= w_kill ? '0 : rd_IDR;
            rf_wr_en_EX   <= w_kill ? 1'b0 : rf_wr_en_IDR;
            rf_wr_sel_EX  <= w_kill ? '0 : rf_wr_sel_IDR;
            dm_rd_ctrl_EX <= w_kill ? '0 : dm_rd_ctrl_IDR;
            dm_wr_ctrl_EX <= w_kill ? '0 : dm_wr_ctrl_IDR;
        end
    end

endmodule
`default_nettype wire
